// File: rtl/mem_loader.sv
// UART-to-BRAM load/dump engine: assembles MSB-first bytes into 32-bit writes and streams words back as bytes.
// Optional trailing XOR checksum on load, enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start_load,
  input  logic              i_start_dump,
  input  logic [8:0]        i_word_count,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_chk_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
`ifdef MEM_LOADER_CHECKSUM_EN
    S_LOAD_CHK  = 3'd2,
`endif
    S_DUMP_ADDR = 3'd3,
    S_DUMP_WAIT = 3'd4,
    S_DUMP_SEND = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [8:0]          rem_q, rem_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [1:0]          tcnt_q, tcnt_d;
  logic [7:0]          tx_byte;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                chk_err_q, chk_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      asm_q     <= '0;
      bcnt_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      word_q    <= '0;
      tcnt_q    <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      asm_q     <= asm_d;
      bcnt_q    <= bcnt_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      word_q    <= word_d;
      tcnt_q    <= tcnt_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    word_d  = word_q;
    tcnt_d  = tcnt_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    chk_err_d = chk_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start_load || i_start_dump) begin
          idx_d  = '0;
          asm_d  = '0;
          bcnt_d = '0;
          tcnt_d = '0;
          rem_d  = (i_word_count > 9'd256) ? 9'd256 : i_word_count;
`ifdef MEM_LOADER_CHECKSUM_EN
          csum_d    = '0;
          chk_err_d = 1'b0;
`endif
          if (i_word_count == 9'd0) state_d = S_DONE;
          else if (i_start_load)    state_d = S_LOAD;
          else                      state_d = S_DUMP_ADDR;
        end
      end
      S_LOAD: begin
        // Index advances at the end of the write cycle so o_mem_addr can mirror it directly.
        if (we_q) idx_d = idx_q + IDX_ONE;
        if (i_rx_valid && rem_q != 9'd0) begin
          asm_d  = {asm_q[DATA_W-9:0], i_rx_data};
          bcnt_d = bcnt_q + 2'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ i_rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = asm_d;
            rem_d   = rem_q - 9'd1;
          end
        end
        // rem_q reaches zero only during the final write cycle.
        if (rem_q == 9'd0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          if (i_rx_valid) begin
            chk_err_d = (i_rx_data != csum_q);
            state_d   = S_DONE;
          end else begin
            state_d = S_LOAD_CHK;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      S_LOAD_CHK: begin
        if (i_rx_valid) begin
          chk_err_d = (i_rx_data != csum_q);
          state_d   = S_DONE;
        end
      end
`endif
      S_DUMP_ADDR: state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        word_d  = i_mem_rdata;
        tcnt_d  = '0;
        state_d = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (i_tx_ready) begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd3) begin
            idx_d   = idx_q + IDX_ONE;
            rem_d   = rem_q - 9'd1;
            state_d = (rem_q == 9'd1) ? S_DONE : S_DUMP_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (tcnt_q)
      2'd0:    tx_byte = word_q[DATA_W-1:DATA_W-8];
      2'd1:    tx_byte = word_q[DATA_W-9:DATA_W-16];
      2'd2:    tx_byte = word_q[DATA_W-17:DATA_W-24];
      default: tx_byte = word_q[DATA_W-25:DATA_W-32];
    endcase
  end

  assign o_mem_we    = we_q;
  assign o_mem_addr  = idx_q;
  assign o_mem_wdata = wdata_q;
  assign o_tx_valid  = (state_q == S_DUMP_SEND);
  assign o_tx_data   = o_tx_valid ? tx_byte : 8'h00;
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done      = (state_q == S_DONE);
`ifdef MEM_LOADER_CHECKSUM_EN
  assign o_chk_err   = chk_err_q;
`else
  assign o_chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a registered-read BRAM model; checks load, dump, arbitration and reset.
// Checksum steps are compiled in when MEM_LOADER_CHECKSUM_EN is defined.
module tb_mem_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_load, start_dump;
  logic [8:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy, done, chk_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int stalls = 0;
  int unstable = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got[$];
  logic [7:0] exp_bytes [8];
  logic [31:0] mem [0:255];
  int cyc;
  int wr_before;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_start_load(start_load), .i_start_dump(start_dump), .i_word_count(word_count),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_done(done), .o_chk_err(chk_err)
  );

  // BRAM with one-cycle registered read
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we) wr_cnt <= wr_cnt + 1;
    if (prev_stall && (!tx_valid || tx_data != prev_data)) unstable <= unstable + 1;
    if (tx_valid && !tx_ready) stalls <= stalls + 1;
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [7:0] csum);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(csum);
`else
    rx_data = csum;
    tick();
`endif
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask

  task automatic run_dump(input bit toggle);
    got.delete();
    cyc = 0;
    while (!done && cyc < 100) begin
      if (toggle) tx_ready = ((cyc % 2) == 1);
      if (tx_valid && tx_ready) got.push_back(tx_data);
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
  endtask

  initial begin
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rst_n = 1'b0; start_load = 1'b0; start_dump = 1'b0; word_count = '0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_chk_err", 32'(chk_err), 0);
    rst_n = 1'b1;
    tick();

    // Load two words, back-to-back bytes
    start_load = 1'b1; word_count = 9'd2;
    tick();
    start_load = 1'b0;
    check("load_busy", 32'(busy), 1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("load_w0_we", 32'(mem_we), 1);
    check("load_w0_addr", 32'(mem_addr), 0);
    check("load_w0_data", mem_wdata, 32'h01020304);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check("load_w1_we", 32'(mem_we), 1);
    check("load_w1_addr", 32'(mem_addr), 1);
    check("load_w1_data", mem_wdata, 32'hAABBCCDD);
    check("load_no_early_done", 32'(done), 0);
    expect_done("load", 8'h04);
    tick();
    check("load_done_pulse", 32'(done), 0);
    check("load_we_low", 32'(mem_we), 0);
    $display("load count=2 words=%h,%h", mem[0], mem[1]);

    // Dump two words, transmitter always ready
    tx_ready = 1'b1; start_dump = 1'b1; word_count = 9'd2;
    tick();
    start_dump = 1'b0;
    check("dump_busy", 32'(busy), 1);
    run_dump(1'b0);
    check("dump_cycles", cyc, 12);
    check("dump_nbytes", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("dump_b%0d", i), 32'(got[i]), 32'(exp_bytes[i]));
    check("dump_busy_at_done", 32'(busy), 0);
    $display("dump ready=1 bytes=%0d cycles=%0d", got.size(), cyc);

    // Dump with ready toggling
    tick();
    start_dump = 1'b1; word_count = 9'd2;
    tick();
    start_dump = 1'b0;
    run_dump(1'b1);
    check("dumpt_done", 32'(done), 1);
    check("dumpt_nbytes", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("dumpt_b%0d", i), 32'(got[i]), 32'(exp_bytes[i]));
    check("dumpt_stalled", 32'(stalls > 0), 1);
    check("dumpt_stable", unstable, 0);
    $display("dump ready=toggle bytes=%0d stalls=%0d", got.size(), stalls);

    // Simultaneous starts -> load; a start while busy is ignored
    tick();
    start_load = 1'b1; start_dump = 1'b1; word_count = 9'd1;
    tick();
    start_load = 1'b0; start_dump = 1'b0;
    check("simul_busy", 32'(busy), 1);
    start_dump = 1'b1; word_count = 9'd2;
    tick();
    start_dump = 1'b0;
    check("simul_no_tx", 32'(tx_valid), 0);
    send_byte(8'h11); tick(); send_byte(8'h22); tick(); send_byte(8'h33); tick(); send_byte(8'h44);
    check("simul_we", 32'(mem_we), 1);
    check("simul_addr", 32'(mem_addr), 0);
    check("simul_data", mem_wdata, 32'h11223344);
    expect_done("simul", 8'h44);
    $display("load via simultaneous start word=%h", mem_wdata);

    // Zero count
    tick();
    wr_before = wr_cnt;
    start_load = 1'b1; word_count = 9'd0;
    tick();
    start_load = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    tick();
    check("zero_done_pulse", 32'(done), 0);
    check("zero_no_write", wr_cnt, wr_before);
    $display("load count=0 writes=%0d", wr_cnt - wr_before);

    // Reset after two bytes of a word
    start_load = 1'b1; word_count = 9'd1;
    tick();
    start_load = 1'b0;
    send_byte(8'h01); send_byte(8'h02);
    wr_before = wr_cnt;
    rst_n = 1'b0;
    tick();
    check("mrst_we", 32'(mem_we), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_addr", 32'(mem_addr), 0);
    check("mrst_wdata", mem_wdata, 0);
    check("mrst_tx_valid", 32'(tx_valid), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("mrst_no_write", wr_cnt, wr_before);
    start_load = 1'b1; word_count = 9'd1;
    tick();
    start_load = 1'b0;
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    check("mrst_reload_we", 32'(mem_we), 1);
    check("mrst_reload_addr", 32'(mem_addr), 0);
    check("mrst_reload_data", mem_wdata, 32'hA1B2C3D4);
    expect_done("mrst_reload", 8'h04);
    $display("reload after reset word=%h", mem_wdata);

`ifdef MEM_LOADER_CHECKSUM_EN
    // Checksum: correct then incorrect trailing byte
    tick();
    start_load = 1'b1; word_count = 9'd1;
    tick();
    start_load = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    tick();
    check("csum_ok_wait", 32'(done), 0);
    send_byte(8'h04);
    check("csum_ok_done", 32'(done), 1);
    check("csum_ok_err", 32'(chk_err), 0);
    tick();
    start_load = 1'b1; word_count = 9'd1;
    tick();
    start_load = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("csum_bad_we", 32'(mem_we), 1);
    check("csum_bad_data", mem_wdata, 32'h01020304);
    expect_done("csum_bad", 8'h05);
    check("csum_bad_err", 32'(chk_err), 1);
    tick(); tick();
    check("csum_bad_err_held", 32'(chk_err), 1);
    $display("checksum trailing=05 chk_err=%0b", chk_err);
`else
    check("nocsum_err", 32'(chk_err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
